// File: rtl/btb_pkg.sv
// Shared types for the BTB update controller: the grant encoding for the
// single array port and the queued-update entry layout.
package btb_pkg;

  // Entry field widths; btb_update_ctrl's W_PC / W_BTA defaults track these
  // and must be kept equal to them.
  localparam int PC_W  = 8;
  localparam int BTA_W = 32;

  // Who owns the single-ported array this cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  // One queued BTB update. 'inv' set means the write removes the tag.
  typedef struct packed {
    logic             inv;
    logic [PC_W-1:0]  pc;
    logic [BTA_W-1:0] bta;
  } upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Update FIFO between the execute stage and the BTB array write port.
// Optional feature: define BTB_UPD_COALESCE_EN to merge an update into a
// queued entry with the same tag instead of allocating a new slot.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  upd_entry_t pushEntry,
  input  logic       pop,
  output logic       ready,
  output logic       empty,
  output logic       full,
  output upd_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  upd_entry_t    mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   count;
  logic          coalesce;
  logic [AW-1:0] coalesceIdx;
  logic          doPush;
  logic          allocate;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

`ifdef BTB_UPD_COALESCE_EN
  // Search live entries for a matching tag; the head is excluded when it
  // leaves this cycle, since overwriting it would lose the update.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    coalesce    = 1'b0;
    coalesceIdx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!coalesce && ((AW+1)'(k) < count) && !(k == 0 && pop) &&
          (mem[rdPtr + AW'(k)].pc == pushEntry.pc)) begin
        coalesce    = 1'b1;
        coalesceIdx = rdPtr + AW'(k);
      end
    end
  end

  assign ready = !full || coalesce;
`else
  assign coalesce    = 1'b0;
  assign coalesceIdx = '0;
  assign ready       = !full;
`endif

  assign doPush   = push && ready;
  assign allocate = doPush && !coalesce;

  // Entry storage: write a new slot at the tail or merge in place.
  // NOTE: the entry array is deliberately not reset; pointers and count alone
  // decide which slots are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (doPush) begin
      if (coalesce) mem[coalesceIdx] <= pushEntry;
      else          mem[wrPtr]       <= pushEntry;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^AW.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (allocate) wrPtr <= wrPtr + 1'b1;
      if (pop)      rdPtr <= rdPtr + 1'b1;
      case ({allocate, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: arbitrates the single-ported BTB array between fetch
// lookups and queued execute-stage updates, with a starvation guard so that
// continuous fetch traffic cannot hold off updates forever.
// Optional feature: BTB_UPD_COALESCE_EN (update merging inside btb_upd_fifo).
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int W_PC       = 8,
  parameter int W_BTA      = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [W_PC-1:0]  fetch_pc,
  output logic             fetch_stall,
  output logic             lookup_valid,
  output logic             lookup_hit,
  output logic [W_BTA-1:0] lookup_bta,
  input  logic             upd_valid,
  input  logic [W_PC-1:0]  upd_pc,
  input  logic [W_BTA-1:0] upd_bta,
  input  logic             upd_taken,
  input  logic             upd_predicted,
  output logic             upd_ready,
  output logic             arr_en,
  output logic             arr_we,
  output logic             arr_inv,
  output logic [W_PC-1:0]  arr_pc,
  output logic [W_BTA-1:0] arr_wdata,
  output logic             arr_clear,
  input  logic             arr_hit,
  input  logic [W_BTA-1:0] arr_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  grant_e        grant;
  logic [SW-1:0] starveCnt;
  logic          rdQ;
  logic          pushReq;
  logic          pop;
  logic          fifoReady;
  logic          fifoEmpty;
  logic          fifoFull;
  upd_entry_t    pushEntry;
  upd_entry_t    head;

  // Only mispredictions change the BTB; an invalidate carries no target.
  assign pushReq   = upd_valid && !reset && (upd_taken != upd_predicted);
  assign pushEntry = '{inv: !upd_taken, pc: upd_pc, bta: upd_taken ? upd_bta : '0};
  assign pop       = (grant == GNT_WR);
  assign upd_ready = fifoReady;

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pushReq),
    .pushEntry (pushEntry),
    .pop       (pop),
    .ready     (fifoReady),
    .empty     (fifoEmpty),
    .full      (fifoFull),
    .head      (head)
  );

  // Port arbitration: drain updates when forced or when fetch is quiet.
  always_comb begin
    grant = GNT_IDLE;
    if (reset) begin
      grant = GNT_IDLE;
    end else if (!fifoEmpty &&
                 (fifoFull || starveCnt == SW'(STARVE_MAX) || !fetch_req)) begin
      grant = GNT_WR;
    end else if (fetch_req) begin
      grant = GNT_RD;
    end
  end

  // Array request signals for the granted operation.
  always_comb begin
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_inv   = 1'b0;
    arr_pc    = '0;
    arr_wdata = '0;
    case (grant)
      GNT_RD: begin
        arr_en = 1'b1;
        arr_pc = fetch_pc;
      end
      GNT_WR: begin
        arr_en    = 1'b1;
        arr_we    = 1'b1;
        arr_inv   = head.inv;
        arr_pc    = head.pc;
        arr_wdata = head.bta;
      end
      default: ;
    endcase
  end

  assign fetch_stall = fetch_req && !reset && (grant != GNT_RD);
  assign arr_clear   = reset;

  // Count consecutive lookups that bypassed a waiting update.
  always_ff @(posedge clk) begin
    if (reset || grant == GNT_WR || fifoEmpty) begin
      starveCnt <= '0;
    end else if (grant == GNT_RD && starveCnt != SW'(STARVE_MAX)) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Remember a lookup so its array response is presented next cycle.
  always_ff @(posedge clk) begin
    if (reset) rdQ <= 1'b0;
    else       rdQ <= (grant == GNT_RD);
  end

  assign lookup_valid = rdQ;
  assign lookup_hit   = rdQ && arr_hit;
  assign lookup_bta   = lookup_hit ? arr_rdata : '0;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_btb_update_ctrl;

  localparam int W_PC       = 8;
  localparam int W_BTA      = 32;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             fetch_req;
  logic [W_PC-1:0]  fetch_pc;
  logic             fetch_stall;
  logic             lookup_valid;
  logic             lookup_hit;
  logic [W_BTA-1:0] lookup_bta;
  logic             upd_valid;
  logic [W_PC-1:0]  upd_pc;
  logic [W_BTA-1:0] upd_bta;
  logic             upd_taken;
  logic             upd_predicted;
  logic             upd_ready;
  logic             arr_en;
  logic             arr_we;
  logic             arr_inv;
  logic [W_PC-1:0]  arr_pc;
  logic [W_BTA-1:0] arr_wdata;
  logic             arr_clear;
  logic             arr_hit;
  logic [W_BTA-1:0] arr_rdata;

  always #5 clk = ~clk;

  btb_update_ctrl #(
    .W_PC(W_PC), .W_BTA(W_BTA), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_bta(lookup_bta),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_bta(upd_bta),
    .upd_taken(upd_taken), .upd_predicted(upd_predicted), .upd_ready(upd_ready),
    .arr_en(arr_en), .arr_we(arr_we), .arr_inv(arr_inv), .arr_pc(arr_pc),
    .arr_wdata(arr_wdata), .arr_clear(arr_clear),
    .arr_hit(arr_hit), .arr_rdata(arr_rdata)
  );

  // Reference model state: pending updates in arrival order.
  typedef struct {
    bit               inv;
    logic [W_PC-1:0]  pc;
    logic [W_BTA-1:0] bta;
  } mentry_t;

  mentry_t q[$];
  int      starve = 0;
  bit      prevRd = 0;

  int total = 0;
  int bad   = 0;

  // Outputs observed in the most recent step, for scenario-level checks.
  logic             obsEn, obsWe, obsInv, obsStall, obsReady, obsValid;
  logic [W_PC-1:0]  obsPc;
  logic [W_BTA-1:0] obsWdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One functional cycle: drive, compare with the model, advance the model.
  task automatic step(input bit fr, input logic [W_PC-1:0] fpc, input bit uv,
                      input logic [W_PC-1:0] upc, input logic [W_BTA-1:0] ubta,
                      input bit ut, input bit up);
    int      sz;
    int      m;
    bit      full, wr, rd, ready, enq, expHit;
    mentry_t ne;
    logic [W_PC-1:0]  expPc;
    logic [W_BTA-1:0] expWdata;
    @(negedge clk);
    reset = 1'b0; fetch_req = fr; fetch_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_bta = ubta; upd_taken = ut; upd_predicted = up;
    arr_hit = 1'($urandom_range(0, 1)); arr_rdata = $urandom();
    #1;
    sz   = q.size();
    full = (sz == DEPTH);
    wr   = (sz > 0) && (full || starve == STARVE_MAX || !fr);
    rd   = !wr && fr;
    m    = -1;
`ifdef BTB_UPD_COALESCE_EN
    for (int i = 0; i < sz; i++)
      if (m < 0 && q[i].pc == upc && !(i == 0 && wr)) m = i;
    ready = !full || (m >= 0);
`else
    ready = !full;
`endif
    expPc    = wr ? q[0].pc  : (rd ? fpc : '0);
    expWdata = wr ? q[0].bta : '0;
    expHit   = prevRd && arr_hit;
    check("upd_ready",    upd_ready,    ready);
    check("fetch_stall",  fetch_stall,  fr && !rd);
    check("arr_en",       arr_en,       wr || rd);
    check("arr_we",       arr_we,       wr);
    check("arr_inv",      arr_inv,      wr && q[0].inv);
    check("arr_pc",       arr_pc,       expPc);
    check("arr_wdata",    arr_wdata,    expWdata);
    check("arr_clear",    arr_clear,    0);
    check("lookup_valid", lookup_valid, prevRd);
    check("lookup_hit",   lookup_hit,   expHit);
    check("lookup_bta",   lookup_bta,   expHit ? arr_rdata : '0);
    obsEn = arr_en; obsWe = arr_we; obsInv = arr_inv; obsStall = fetch_stall;
    obsReady = upd_ready; obsValid = lookup_valid; obsPc = arr_pc; obsWdata = arr_wdata;
    @(posedge clk);
    enq    = uv && ready && (ut != up);
    ne.inv = !ut;
    ne.pc  = upc;
    ne.bta = ut ? ubta : '0;
    if (enq && m >= 0) q[m] = ne;
    if (wr) void'(q.pop_front());
    if (enq && m < 0) q.push_back(ne);
    if (wr || sz == 0) starve = 0;
    else if (rd && starve < STARVE_MAX) starve++;
    prevRd = rd;
  endtask

  // One reset cycle with live-looking inputs that must be ignored.
  task automatic rst_step(input bit fr);
    @(negedge clk);
    reset = 1'b1; fetch_req = fr; fetch_pc = 8'($urandom());
    upd_valid = 1'b1; upd_pc = 8'($urandom()); upd_bta = $urandom();
    upd_taken = 1'b1; upd_predicted = 1'b0;
    #1;
    check("rst_arr_clear",   arr_clear,   1);
    check("rst_arr_en",      arr_en,      0);
    check("rst_arr_we",      arr_we,      0);
    check("rst_arr_inv",     arr_inv,     0);
    check("rst_fetch_stall", fetch_stall, 0);
    @(posedge clk);
    q.delete();
    starve = 0;
    prevRd = 0;
  endtask

  task automatic rand_step();
    step(($urandom_range(0, 9) < 7), 8'($urandom()), ($urandom_range(0, 9) < 6),
         8'(8'h40 + $urandom_range(0, 5)), $urandom(),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int wrs;
    reset = 1'b1; fetch_req = 1'b1; fetch_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_bta = '0; upd_taken = 1'b0; upd_predicted = 1'b0;
    arr_hit = 1'b0; arr_rdata = '0;

    // Two reset cycles with fetch requesting, then release.
    rst_step(1);
    rst_step(1);
    step(0, 8'h00, 0, 8'h00, 32'h0, 0, 0);
    check("post_rst_valid", obsValid, 0);
    check("post_rst_ready", obsReady, 1);

    // Taken-not-predicted insert written next cycle while fetch is idle.
    step(0, 8'h00, 1, 8'h08, 32'h1234, 1, 0);
    step(0, 8'h00, 0, 8'h00, 32'h0, 0, 0);
    check("ins_we",    obsWe,    1);
    check("ins_pc",    obsPc,    8'h08);
    check("ins_wdata", obsWdata, 32'h1234);
    check("ins_inv",   obsInv,   0);

    // Correct prediction is dropped; predicted-not-taken invalidates.
    step(0, 8'h00, 1, 8'h11, 32'h55, 1, 1);
    step(0, 8'h00, 0, 8'h00, 32'h0, 0, 0);
    check("drop_no_wr", obsEn, 0);
    step(0, 8'h00, 1, 8'h12, 32'h77, 0, 1);
    step(0, 8'h00, 0, 8'h00, 32'h0, 0, 0);
    check("inv_we", obsWe,  1);
    check("inv_inv", obsInv, 1);
    check("inv_pc", obsPc,  8'h12);

    // Starvation: three lookups, then a forced write, then lookups resume.
    step(1, 8'h01, 1, 8'h20, 32'hABC, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'(i), 0, 8'h00, 32'h0, 0, 0);
      check("starve_stall", obsStall, (i == 3));
      check("starve_we",    obsWe,    (i == 3));
    end
    step(1, 8'h05, 0, 8'h00, 32'h0, 0, 0);
    check("resume_stall", obsStall, 0);
    check("resume_we",    obsWe,    0);

    // Fill the FIFO under fetch pressure; full forces a write.
    for (int i = 0; i < 4; i++) step(1, 8'h02, 1, 8'(8'h30 + i), 32'(i + 1), 1, 0);
    step(1, 8'h02, 1, 8'h34, 32'h9, 1, 0);
    check("full_ready", obsReady, 0);
    check("full_we",    obsWe,    1);
    step(1, 8'h02, 0, 8'h00, 32'h0, 0, 0);
    check("after_pop_ready", obsReady, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 8'h00, 32'h0, 0, 0);

`ifdef BTB_UPD_COALESCE_EN
    // Two updates to the same tag collapse into one write of the newer target.
    step(1, 8'h03, 1, 8'h16, 32'h100, 1, 0);
    step(1, 8'h03, 1, 8'h16, 32'h200, 1, 0);
    wrs = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 8'h03, 0, 8'h00, 32'h0, 0, 0);
      if (obsWe) begin
        wrs++;
        check("coal_wdata", obsWdata, 32'h200);
      end
    end
    check("coal_writes", wrs, 1);
`endif

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_step(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) rst_step(1);
      end
      rand_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
